// File: rtl/mcoi_bram_mailbox_responder_pkg.sv
// Shared mailbox record layouts, status codes and FSM states for the PS<->PL BRAM mailbox.
// Also used by the PS-side software header generator.
package mcoi_bram_mailbox_responder_pkg;

   typedef struct packed {
      logic        valid;
      logic [6:0]  seq;
      logic [7:0]  opcode;
      logic [15:0] len;
   } mbox_hdr_t;

   typedef struct packed {
      logic        done;
      logic [6:0]  seq;
      logic [7:0]  status;
      logic [15:0] count;
   } mbox_rsp_t;

   localparam logic [7:0] MBOX_OK      = 8'h00;
   localparam logic [7:0] MBOX_BAD_LEN = 8'hFD;
   localparam logic [7:0] MBOX_TIMEOUT = 8'hFE;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_HDR,
      S_WAIT_HDR,
      S_CHECK,
      S_RD_PAY,
      S_WAIT_PAY,
      S_PRESENT,
      S_WAIT_RSP,
      S_WR_RSP,
      S_CLR_HDR
   } mbox_state_t;

   function automatic mbox_hdr_t mbox_hdr_unpack(input logic [31:0] w);
      return mbox_hdr_t'(w);
   endfunction

   function automatic logic [31:0] mbox_hdr_clear(input mbox_hdr_t h);
      mbox_hdr_t c;
      c       = h;
      c.valid = 1'b0;
      return c;
   endfunction

   function automatic logic [31:0] mbox_rsp_pack(input logic [6:0]  seq,
                                                 input logic [7:0]  status,
                                                 input logic [15:0] count);
      mbox_rsp_t r;
      r.done   = 1'b1;
      r.seq    = seq;
      r.status = status;
      r.count  = count;
      return r;
   endfunction

endpackage

// File: rtl/mcoi_bram_mailbox_responder.sv
// PL-side mailbox responder: polls the command header over BRAM port B, streams the payload
// to the app, writes the response record and clears VALID. Optional: MCOI_MAILBOX_TIMEOUT_EN.
module mcoi_bram_mailbox_responder
   import mcoi_bram_mailbox_responder_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int CMD_BASE    = 0,
   parameter int RSP_BASE    = 512,
   parameter int MAX_LEN     = 255,
   parameter int POLL_CYCLES = 1024,
   parameter int TIMEOUT     = 2**20
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              bram_en,
   output logic [3:0]        bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [31:0]       bram_din,
   input  logic [31:0]       bram_dout,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [7:0]        cmd_opcode,
   output logic [31:0]       cmd_data,
   output logic              cmd_first,
   output logic              cmd_last,
   input  logic              rsp_valid,
   input  logic [7:0]        rsp_status,
   output logic              busy,
   output logic              done_pulse
);

   localparam int POLL_W = $clog2(POLL_CYCLES);

   mbox_state_t       r_state, w_next;
   logic [POLL_W-1:0] r_poll;
   logic [31:0]       r_hdr_raw;
   logic [15:0]       r_idx;
   logic [31:0]       r_data;
   logic [7:0]        r_status;
   logic              r_done;

   mbox_hdr_t         w_hdr;
   logic              w_poll_hit;
   logic              w_last;
   logic              w_tmo_hit;
   logic [ADDR_W-1:0] w_pay_addr;

   assign w_hdr      = mbox_hdr_unpack(r_hdr_raw);
   assign w_poll_hit = (r_poll == POLL_W'(POLL_CYCLES - 1));
   assign w_last     = (r_idx == w_hdr.len - 16'd1);
   assign w_pay_addr = ADDR_W'(CMD_BASE + 1 + int'(r_idx));

`ifdef MCOI_MAILBOX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT);
   logic [TMO_W-1:0] r_tmo;

   // Counts only while stalled on the app; any state change or handshake restarts it.
   always_ff @(posedge clk) begin
      if (!reset_n)
         r_tmo <= '0;
      else if ((r_state == S_PRESENT && !cmd_ready) || (r_state == S_WAIT_RSP && !rsp_valid))
         r_tmo <= r_tmo + TMO_W'(1);
      else
         r_tmo <= '0;
   end

   assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   // Poll counter free-runs so VALID=0 headers are re-read at a fixed POLL_CYCLES period.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_poll    <= '0;
         r_hdr_raw <= '0;
         r_idx     <= '0;
         r_data    <= '0;
         r_status  <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_poll  <= w_poll_hit ? '0 : r_poll + POLL_W'(1);
         r_done  <= (r_state == S_CLR_HDR);
         case (r_state)
            S_WAIT_HDR: r_hdr_raw <= bram_dout;
            S_CHECK: begin
               r_idx <= '0;
               if (w_hdr.len > 16'(MAX_LEN))
                  r_status <= MBOX_BAD_LEN;
            end
            S_WAIT_PAY: r_data <= bram_dout;
            S_PRESENT: begin
               if (cmd_ready)
                  r_idx <= r_idx + 16'd1;
               else if (w_tmo_hit)
                  r_status <= MBOX_TIMEOUT;
            end
            S_WAIT_RSP: begin
               if (rsp_valid)
                  r_status <= rsp_status;
               else if (w_tmo_hit)
                  r_status <= MBOX_TIMEOUT;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      bram_en   = 1'b0;
      bram_we   = 4'h0;
      bram_addr = '0;
      bram_din  = '0;
      busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_poll_hit)
               w_next = S_RD_HDR;
         end
         S_RD_HDR: begin
            bram_en   = 1'b1;
            bram_addr = ADDR_W'(CMD_BASE);
            w_next    = S_WAIT_HDR;
         end
         S_WAIT_HDR: w_next = S_CHECK;
         S_CHECK: begin
            if (!w_hdr.valid)
               w_next = S_IDLE;
            else if (w_hdr.len > 16'(MAX_LEN))
               w_next = S_WR_RSP;
            else if (w_hdr.len == 16'd0)
               w_next = S_WAIT_RSP;
            else
               w_next = S_RD_PAY;
         end
         S_RD_PAY: begin
            busy      = 1'b1;
            bram_en   = 1'b1;
            bram_addr = w_pay_addr;
            w_next    = S_WAIT_PAY;
         end
         S_WAIT_PAY: begin
            busy   = 1'b1;
            w_next = S_PRESENT;
         end
         S_PRESENT: begin
            busy = 1'b1;
            if (cmd_ready)
               w_next = w_last ? S_WAIT_RSP : S_RD_PAY;
            else if (w_tmo_hit)
               w_next = S_WR_RSP;
         end
         S_WAIT_RSP: begin
            busy = 1'b1;
            if (rsp_valid || w_tmo_hit)
               w_next = S_WR_RSP;
         end
         S_WR_RSP: begin
            busy      = 1'b1;
            bram_en   = 1'b1;
            bram_we   = 4'hF;
            bram_addr = ADDR_W'(RSP_BASE);
            bram_din  = mbox_rsp_pack(w_hdr.seq, r_status, r_idx);
            w_next    = S_CLR_HDR;
         end
         S_CLR_HDR: begin
            busy      = 1'b1;
            bram_en   = 1'b1;
            bram_we   = 4'hF;
            bram_addr = ADDR_W'(CMD_BASE);
            bram_din  = mbox_hdr_clear(w_hdr);
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign cmd_valid  = (r_state == S_PRESENT);
   assign cmd_data   = cmd_valid ? r_data : '0;
   assign cmd_opcode = cmd_valid ? w_hdr.opcode : '0;
   assign cmd_first  = cmd_valid && (r_idx == 16'd0);
   assign cmd_last   = cmd_valid && w_last;
   assign done_pulse = r_done;

endmodule

// File: tb/tb_mcoi_bram_mailbox_responder.sv
// Randomized self-checking bench for mcoi_bram_mailbox_responder with a BRAM/PS/app model.
// Timeout scenario is built only when MCOI_MAILBOX_TIMEOUT_EN is defined.
module tb_mcoi_bram_mailbox_responder;

   localparam int ADDR_W   = 10;
   localparam int CMD_BASE = 0;
   localparam int RSP_BASE = 512;
   localparam int MAX_LEN  = 255;
   localparam int POLL     = 16;
   localparam int TMO      = 64;

   logic              clk;
   logic              reset_n;
   logic              bram_en;
   logic [3:0]        bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [31:0]       bram_din;
   logic [31:0]       bram_dout;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [7:0]        cmd_opcode;
   logic [31:0]       cmd_data;
   logic              cmd_first;
   logic              cmd_last;
   logic              rsp_valid;
   logic [7:0]        rsp_status;
   logic              busy;
   logic              done_pulse;

   mcoi_bram_mailbox_responder #(
      .ADDR_W(ADDR_W), .CMD_BASE(CMD_BASE), .RSP_BASE(RSP_BASE),
      .MAX_LEN(MAX_LEN), .POLL_CYCLES(POLL), .TIMEOUT(TMO)
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_din(bram_din), .bram_dout(bram_dout),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_data(cmd_data), .cmd_first(cmd_first), .cmd_last(cmd_last),
      .rsp_valid(rsp_valid), .rsp_status(rsp_status),
      .busy(busy), .done_pulse(done_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Shared BRAM: port B is the DUT, the PS side writes through ps_wr.
   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic              ps_wr;
   logic [ADDR_W-1:0] ps_addr;
   logic [31:0]       ps_data;

   always @(posedge clk) begin
      if (ps_wr)
         mem[ps_addr] <= ps_data;
      if (bram_en) begin
         if (bram_we != 4'h0) begin
            for (int b = 0; b < 4; b++)
               if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
         end else begin
            bram_dout <= mem[bram_addr];
         end
      end
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] pay [0:15];
   logic [31:0] cur_hdr;
   logic [7:0]  cur_st;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic ps_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      @(negedge clk);
      ps_wr   = 1'b1;
      ps_addr = a;
      ps_data = d;
      @(negedge clk);
      ps_wr   = 1'b0;
   endtask

   task automatic setup_cmd(input logic [6:0] seq, input logic [7:0] op, input logic [15:0] len,
                            input logic [7:0] st, input bit fixed);
      int n;
      cur_hdr = {1'b1, seq, op, len};
      cur_st  = st;
      n = (len > 16'(MAX_LEN)) ? 0 : int'(len);
      for (int k = 0; k < n; k++) begin
         pay[k] = fixed ? 32'hA + 32'(k) : $urandom;
         ps_write(ADDR_W'(CMD_BASE + 1 + k), pay[k]);
      end
      ps_write(ADDR_W'(RSP_BASE), 32'h0);
      ps_write(ADDR_W'(CMD_BASE), cur_hdr);
   endtask

   // mode: 0 random ready, 1 stall 50 cycles on word 1, 2 reset while word 1 presented,
   //       3 app never ready (timeout build only)
   task automatic run_cmd(input int mode);
      logic [15:0] len;
      logic [7:0]  exp_st;
      logic [31:0] exp_rsp, snap;
      int          exp_beats, beats, writes, dones, stall_left, stall_bad, first_v, wr_c;
      logic [ADDR_W-1:0] first_wr;
      bit          saw_busy, strobed, finished, aborted;

      len       = cur_hdr[15:0];
      exp_beats = (len > 16'(MAX_LEN)) ? 0 : int'(len);
      exp_st    = (len > 16'(MAX_LEN)) ? 8'hFD : cur_st;
      if (mode == 3) begin
         exp_beats = 0;
         exp_st    = 8'hFE;
      end
      exp_rsp = {1'b1, cur_hdr[30:24], exp_st, 16'(exp_beats)};

      beats = 0; writes = 0; dones = 0; stall_left = 50; stall_bad = 0;
      first_v = -1; wr_c = -1; first_wr = '0; snap = '0;
      saw_busy = 0; strobed = 0; finished = 0; aborted = 0;

      for (int c = 0; c < 3000 && !finished && !aborted; c++) begin
         @(negedge clk);
         if (bram_en && bram_we != 4'h0) begin
            if (writes == 0) begin
               first_wr = bram_addr;
               wr_c     = c;
            end
            writes++;
         end
         if (busy) saw_busy = 1;
         if (cmd_valid && first_v < 0) first_v = c;
         if (done_pulse) begin
            dones++;
            finished = 1;
         end
         rsp_valid  = 1'b0;
         rsp_status = 8'h00;
         case (mode)
            1: begin
               cmd_ready = 1'b1;
               if (cmd_valid && beats == 1 && stall_left > 0) begin
                  if (stall_left == 50) snap = {cmd_data[29:0], cmd_first, cmd_last};
                  if ({cmd_data[29:0], cmd_first, cmd_last} !== snap || bram_en) stall_bad++;
                  cmd_ready = 1'b0;
                  stall_left--;
               end
            end
            2: begin
               cmd_ready = 1'b1;
               if (cmd_valid && beats == 1) begin
                  reset_n   = 1'b0;
                  cmd_ready = 1'b0;
                  aborted   = 1;
               end
            end
            3: cmd_ready = 1'b0;
            default: cmd_ready = 1'($urandom_range(0, 1));
         endcase
         if (!aborted) begin
            if (mode != 3 && !strobed && busy && !cmd_valid && beats == exp_beats) begin
               if ($urandom_range(0, 2) == 0) begin
                  rsp_valid  = 1'b1;
                  rsp_status = cur_st;
                  strobed    = 1;
               end
            end else if (cmd_valid && $urandom_range(0, 3) == 0) begin
               rsp_valid  = 1'b1;
               rsp_status = 8'h77;
            end
            if (cmd_valid && cmd_ready) begin
               if (beats < exp_beats) begin
                  chk("beat_data", cmd_data, pay[beats]);
                  chk("beat_flags", {22'h0, cmd_first, cmd_last, cmd_opcode},
                      {22'h0, beats == 0, beats == exp_beats - 1, cur_hdr[23:16]});
               end
               beats++;
            end
         end
      end
      rsp_valid = 1'b0;
      cmd_ready = 1'b0;

      if (aborted) begin
         @(negedge clk);
         chk("abort_outs", {22'h0, cmd_valid, busy, bram_en, bram_we, done_pulse, cmd_first, cmd_last}, 32'h0);
         reset_n = 1'b1;
         chk("abort_hdr_valid", 32'(mem[CMD_BASE][31]), 32'h1);
         chk("abort_no_rsp", mem[RSP_BASE], 32'h0);
      end else begin
         chk("done_seen", 32'(finished), 32'h1);
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done_pulse) dones++;
         end
         chk("beats", beats, exp_beats);
         chk("writes", writes, 2);
         chk("rsp_first", 32'(first_wr), RSP_BASE);
         chk("rsp_word", mem[RSP_BASE], exp_rsp);
         chk("hdr_cleared", mem[CMD_BASE], {1'b0, cur_hdr[30:0]});
         chk("done_once", dones, 1);
         if (exp_beats > 0) chk("busy_seen", 32'(saw_busy), 32'h1);
         if (mode == 1) chk("stall_stable", stall_bad, 0);
         if (mode == 3) chk("tmo_cycles", wr_c - first_v, TMO);
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int last_rd, nrd, wr, bsy;
      logic [15:0] rl;
      reset_n = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_status = 8'h0;
      ps_wr = 1'b0; ps_addr = '0; ps_data = '0;
      ps_write(ADDR_W'(CMD_BASE), 32'h0);
      ps_write(ADDR_W'(RSP_BASE), 32'h0);
      @(negedge clk);
      chk("rst_ctl", {22'h0, bram_en, bram_we, cmd_valid, cmd_first, cmd_last, busy, done_pulse}, 32'h0);
      chk("rst_data", bram_din | cmd_data, 32'h0);
      chk("rst_addr_op", {14'h0, bram_addr, cmd_opcode}, 32'h0);
      reset_n = 1'b1;

      // Directed example: SEQ 5, op 3, two words, status OK.
      setup_cmd(7'd5, 8'd3, 16'd2, 8'h00, 1);
      run_cmd(0);
      chk("ex1_rsp", mem[RSP_BASE], 32'h8500_0002);
      chk("ex1_hdr", mem[CMD_BASE], 32'h0503_0002);

      // Oversized length is refused without streaming.
      setup_cmd(7'($urandom), 8'($urandom), 16'h0100, 8'h00, 0);
      run_cmd(0);

      // Length exactly MAX_LEN boundary is not exercised in full; LEN=0 goes straight to status.
      setup_cmd(7'($urandom), 8'($urandom), 16'd0, 8'h3C, 0);
      run_cmd(0);

      // Mid-stream stall.
      setup_cmd(7'($urandom), 8'($urandom), 16'd3, 8'h11, 0);
      run_cmd(1);

      // Idle header: periodic polling, no writes.
      ps_write(ADDR_W'(CMD_BASE), 32'h0503_0002);
      last_rd = -1; nrd = 0; wr = 0; bsy = 0;
      for (int c = 0; c < 5 * POLL; c++) begin
         @(negedge clk);
         if (bram_en && bram_we == 4'h0) begin
            chk("poll_addr", 32'(bram_addr), CMD_BASE);
            if (nrd > 0) chk("poll_period", c - last_rd, POLL);
            last_rd = c;
            nrd++;
         end
         if (bram_we != 4'h0) wr++;
         if (busy || cmd_valid) bsy++;
      end
      chk("poll_reads", 32'(nrd >= 4), 32'h1);
      chk("poll_no_wr", wr, 0);
      chk("poll_idle", bsy, 0);

      // Reset during word 1 of 3, then full reprocessing from word 0.
      setup_cmd(7'd9, 8'h42, 16'd3, 8'h05, 0);
      run_cmd(2);
      run_cmd(0);

`ifdef MCOI_MAILBOX_TIMEOUT_EN
      setup_cmd(7'd12, 8'h21, 16'd3, 8'h00, 0);
      run_cmd(3);
`endif

      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 5))
            0: rl = 16'd0;
            1: rl = 16'(256 + $urandom_range(0, 200));
            default: rl = 16'($urandom_range(1, 6));
         endcase
         setup_cmd(7'($urandom), 8'($urandom), rl, 8'($urandom_range(0, 250)), 0);
         run_cmd(0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
